// File: rtl/datapath_pkg.sv
// Shared definitions for the accumulator datapath: ALU control-word field
// positions, op codes, full control-word encodings and operand mux selects.
// Optional feature macro used by the design: DATAPATH_OVF_EN.
package datapath_pkg;

  // Bit positions inside the 5-bit ALU control word
  localparam int ALU_BZERO = 4;  // force B operand to zero
  localparam int ALU_BINV  = 3;  // invert B operand (after zeroing)
  localparam int ALU_CIN   = 2;  // adder carry-in
  localparam int ALU_OP_HI = 1;
  localparam int ALU_OP_LO = 0;

  // Operation field alu[1:0]
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_AND   = 2'b01,
    ALU_PASSA = 2'b10,
    ALU_PASSB = 2'b11
  } alu_op_e;

  // Full control words emitted by the decoder
  localparam logic [4:0] ALU_W_ADD = 5'b00000;
  localparam logic [4:0] ALU_W_SUB = 5'b01100;  // A + ~B + 1, cout=1 means no borrow
  localparam logic [4:0] ALU_W_INC = 5'b10100;  // A + 0 + 1
  localparam logic [4:0] ALU_W_AND = 5'b00001;
  localparam logic [4:0] ALU_W_OUT = 5'b00010;  // pass A
  localparam logic [4:0] ALU_W_LDB = 5'b00011;  // pass B

  // Operand / address mux selects
  localparam logic MUXA_ACC  = 1'b0;
  localparam logic MUXA_PC   = 1'b1;
  localparam logic MUXB_IMM  = 1'b0;
  localparam logic MUXB_DIN  = 1'b1;
  localparam logic MUXC_PC   = 1'b0;
  localparam logic MUXC_IMM  = 1'b1;

endpackage

// File: rtl/datapath_alu.sv
// dp_alu: combinational ALU for the accumulator datapath. Conditions the B
// operand (zero, then invert), adds with carry-in, or performs AND / pass-A /
// pass-B. With DATAPATH_OVF_EN defined it also reports signed overflow of the
// add path.
module dp_alu
  import datapath_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [4:0]    alu,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] res,
  output logic          cout
`ifdef DATAPATH_OVF_EN
  ,
  output logic          ovf
`endif
);

  logic [DW-1:0] bp;
  logic [DW:0]   sum;
  alu_op_e       op;

  // Operand conditioning, adder and result select
  always_comb begin
    bp = alu[ALU_BZERO] ? '0 : b;
    if (alu[ALU_BINV]) bp = ~bp;
    sum = {1'b0, a} + {1'b0, bp} + {{DW{1'b0}}, alu[ALU_CIN]};
    op  = alu_op_e'(alu[ALU_OP_HI:ALU_OP_LO]);
    res  = '0;
    cout = 1'b0;
    unique case (op)
      ALU_ADD:   begin res = sum[DW-1:0]; cout = sum[DW]; end
      ALU_AND:   res = a & bp;
      ALU_PASSA: res = a;
      ALU_PASSB: res = bp;
      default:   res = '0;
    endcase
  end

`ifdef DATAPATH_OVF_EN
  // Signed overflow: like-signed operands producing a result of the other sign
  always_comb begin
    ovf = (op == ALU_ADD) && (a[DW-1] == bp[DW-1]) && (res[DW-1] != a[DW-1]);
  end
`endif

endmodule

// File: rtl/datapath.sv
// datapath: accumulator datapath steered by the decoder's control word.
// Holds IR, ACC, PC and carry/zero flags, selects ALU operands and the
// memory address, and drives write data / write strobe combinationally.
// Optional feature macro: DATAPATH_OVF_EN adds a signed-overflow flag and
// the ovf output port.
module datapath
  import datapath_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [4:0]    alu,
  input  logic          muxa,
  input  logic          muxb,
  input  logic          muxc,
  input  logic          rw,
  input  logic          en_ir,
  input  logic          en_da,
  input  logic          en_pc,
  input  logic [DW-1:0] data_in,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_out,
  output logic          we,
  output logic [DW-1:0] ir,
  output logic          carry,
  output logic          zero
`ifdef DATAPATH_OVF_EN
  ,
  output logic          ovf
`endif
);

  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;

  logic [DW-1:0] pc_ext, imm_dw, opa, opb, res;
  logic [AW-1:0] imm_aw;
  logic          cout;

  // Zero-extended PC and ir[3:0] immediate, then A/B/address muxes
  always_comb begin
    pc_ext = '0;
    pc_ext[AW-1:0] = pc_q;
    imm_dw = '0;
    imm_dw[3:0] = ir_q[3:0];
    imm_aw = '0;
    imm_aw[3:0] = ir_q[3:0];
    opa  = (muxa == MUXA_PC)  ? pc_ext  : acc_q;
    opb  = (muxb == MUXB_DIN) ? data_in : imm_dw;
    addr = (muxc == MUXC_IMM) ? imm_aw  : pc_q;
  end

`ifdef DATAPATH_OVF_EN
  logic ovf_q, ovf_d, alu_ovf;

  dp_alu #(.DW(DW)) u_alu (
    .alu  (alu),
    .a    (opa),
    .b    (opb),
    .res  (res),
    .cout (cout),
    .ovf  (alu_ovf)
  );
`else
  dp_alu #(.DW(DW)) u_alu (
    .alu  (alu),
    .a    (opa),
    .b    (opb),
    .res  (res),
    .cout (cout)
  );
`endif

  // Next-state: each register loads independently from this cycle's res/data_in
  always_comb begin
    ir_d    = en_ir ? data_in : ir_q;
    acc_d   = en_da ? res : acc_q;
    zero_d  = en_da ? (res == '0) : zero_q;
    carry_d = en_da ? cout : carry_q;
    pc_d    = en_pc ? res[AW-1:0] : pc_q;
  end

  // Architectural registers, cleared immediately by clr
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ir_q    <= '0;
      acc_q   <= '0;
      pc_q    <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      pc_q    <= pc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

`ifdef DATAPATH_OVF_EN
  // Overflow flag only moves with en_da; non-add ops clear it
  always_comb begin
    ovf_d = en_da ? alu_ovf : ovf_q;
  end

  // Overflow flag register, cleared with the other flags
  always_ff @(posedge clk or posedge clr) begin
    if (clr) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  assign data_out = res;
  assign we       = rw;
  assign ir       = ir_q;
  assign carry    = carry_q;
  assign zero     = zero_q;

endmodule
